// File: rtl/hack_cpu_ctrl.sv
// Hack CPU control/register stage: fetch, decode, A/D/PC registers and ready-handshaked data memory.
// Optional HALT state on a taken self-jump when HACK_HALT_DETECT_EN is defined.
module hack_cpu_ctrl #(
    parameter int unsigned PC_W     = 15,
    parameter int unsigned RESET_PC = 0
) (
    input  logic            clk,
    input  logic            rst_n,
    output logic            fetch_req,
    output logic [PC_W-1:0] pc,
    input  logic [15:0]     instr,
    input  logic            instr_valid,
    input  logic [15:0]     inM,
    output logic            mem_req,
    output logic            writeM,
    output logic [PC_W-1:0] addressM,
    output logic [15:0]     outM,
    input  logic            mem_ready,
    output logic [15:0]     alu_x,
    output logic [15:0]     alu_y,
    output logic            zx,
    output logic            nx,
    output logic            zy,
    output logic            ny,
    output logic            f,
    output logic            no,
    input  logic [15:0]     alu_out
`ifdef HACK_HALT_DETECT_EN
    ,
    output logic            halted
`endif
);

    localparam logic [PC_W-1:0] RST_PC = PC_W'(RESET_PC);

    typedef enum logic [1:0] {
        S_FETCH,
        S_EXEC
`ifdef HACK_HALT_DETECT_EN
        ,
        S_HALT
`endif
    } state_t;

    state_t          state;
    logic [15:0]     a_reg;
    logic [15:0]     d_reg;
    logic [15:0]     ir;

    logic            is_c;
    logic            c_a;
    logic            d1, d2, d3;
    logic            needs_mem;
    logic            neg, zero, pos;
    logic            jump;
    logic [PC_W-1:0] pc_inc;
    logic [PC_W-1:0] jump_tgt;
    logic            unused_ir_bits;

    // Bits 14:13 of a C-instruction carry no meaning.
    assign unused_ir_bits = ^ir[14:13];

    assign is_c      = ir[15];
    assign c_a       = ir[12];
    assign d1        = ir[5];
    assign d2        = ir[4];
    assign d3        = ir[3];
    assign needs_mem = is_c & (c_a | d3);

    assign {zx, nx, zy, ny, f, no} = ir[11:6];
    assign alu_x    = d_reg;
    assign alu_y    = (is_c && c_a) ? inM : a_reg;
    assign addressM = a_reg[PC_W-1:0];
    assign outM     = alu_out;

    // Flags derived locally from the result rather than taken from the ALU.
    assign neg      = alu_out[15];
    assign zero     = (alu_out == '0);
    assign pos      = !neg && !zero;
    assign jump     = is_c && ((ir[2] && neg) || (ir[1] && zero) || (ir[0] && pos));
    assign pc_inc   = pc + PC_W'(1);
    assign jump_tgt = a_reg[PC_W-1:0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_FETCH;
            pc        <= RST_PC;
            a_reg     <= '0;
            d_reg     <= '0;
            ir        <= '0;
            fetch_req <= 1'b1;
            mem_req   <= 1'b0;
            writeM    <= 1'b0;
`ifdef HACK_HALT_DETECT_EN
            halted    <= 1'b0;
`endif
        end else begin
            case (state)
                S_FETCH: begin
                    if (instr_valid) begin
                        ir        <= instr;
                        state     <= S_EXEC;
                        fetch_req <= 1'b0;
                        // Memory strobes are decoded from the incoming word so they are registered on EXEC entry.
                        mem_req   <= instr[15] & (instr[12] | instr[3]);
                        writeM    <= instr[15] & instr[3];
                    end
                end
                S_EXEC: begin
                    if (!is_c) begin
                        a_reg     <= ir;
                        pc        <= pc_inc;
                        state     <= S_FETCH;
                        fetch_req <= 1'b1;
                    end else if (!needs_mem || mem_ready) begin
                        if (d1) a_reg <= alu_out;
                        if (d2) d_reg <= alu_out;
                        pc      <= jump ? jump_tgt : pc_inc;
                        mem_req <= 1'b0;
                        writeM  <= 1'b0;
`ifdef HACK_HALT_DETECT_EN
                        if (jump && (jump_tgt == pc)) begin
                            state     <= S_HALT;
                            halted    <= 1'b1;
                            fetch_req <= 1'b0;
                        end else begin
                            state     <= S_FETCH;
                            fetch_req <= 1'b1;
                        end
`else
                        state     <= S_FETCH;
                        fetch_req <= 1'b1;
`endif
                    end
                end
`ifdef HACK_HALT_DETECT_EN
                S_HALT: begin
                    fetch_req <= 1'b0;
                    mem_req   <= 1'b0;
                    writeM    <= 1'b0;
                end
`endif
                default: begin
                    state     <= S_FETCH;
                    fetch_req <= 1'b1;
                    mem_req   <= 1'b0;
                    writeM    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_hack_cpu_ctrl.sv
// Self-checking bench for hack_cpu_ctrl: directed vector table, reset corner cases and random programs
// checked against an instruction-level model of the Hack machine.
module tb_hack_cpu_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        fetch_req;
    logic [14:0] pc;
    logic [15:0] instr = '0;
    logic        instr_valid = 1'b0;
    logic [15:0] inM = '0;
    logic        mem_req;
    logic        writeM;
    logic [14:0] addressM;
    logic [15:0] outM;
    logic        mem_ready = 1'b0;
    logic [15:0] alu_x, alu_y;
    logic        zx, nx, zy, ny, f, no;
    logic [15:0] alu_out;
`ifdef HACK_HALT_DETECT_EN
    logic        halted;
`endif

    int n_checks = 0;
    int n_errors = 0;
    int wr_cnt   = 0;

    logic [15:0] m_a, m_d;
    logic [14:0] m_pc;
    logic        m_halted;

    hack_cpu_ctrl #(.PC_W(15), .RESET_PC(0)) dut (
        .clk(clk), .rst_n(rst_n), .fetch_req(fetch_req), .pc(pc),
        .instr(instr), .instr_valid(instr_valid), .inM(inM),
        .mem_req(mem_req), .writeM(writeM), .addressM(addressM), .outM(outM),
        .mem_ready(mem_ready), .alu_x(alu_x), .alu_y(alu_y),
        .zx(zx), .nx(nx), .zy(zy), .ny(ny), .f(f), .no(no), .alu_out(alu_out)
`ifdef HACK_HALT_DETECT_EN
        , .halted(halted)
`endif
    );

    always #5 clk = ~clk;

    // Hack ALU closing the loop around the DUT.
    logic [15:0] ax, ay, ao;
    always_comb begin
        ax = zx ? 16'h0 : alu_x;
        if (nx) ax = ~ax;
        ay = zy ? 16'h0 : alu_y;
        if (ny) ay = ~ay;
        ao = f ? (ax + ay) : (ax & ay);
        if (no) ao = ~ao;
        alu_out = ao;
    end

    always @(posedge clk) if (mem_req && writeM && mem_ready) wr_cnt++;

    localparam logic [5:0] COMPS [18] = '{
        6'b101010, 6'b111111, 6'b111010, 6'b001100, 6'b110000, 6'b001101,
        6'b110001, 6'b001111, 6'b110011, 6'b011111, 6'b110111, 6'b001110,
        6'b110010, 6'b000010, 6'b010011, 6'b000111, 6'b000000, 6'b010101};

    // Mnemonic-level meaning of each Hack comp field.
    function automatic logic [15:0] model_comp(input logic [5:0] c, input logic [15:0] x, input logic [15:0] y);
        case (c)
            6'b101010: return 16'd0;
            6'b111111: return 16'd1;
            6'b111010: return 16'hFFFF;
            6'b001100: return x;
            6'b110000: return y;
            6'b001101: return ~x;
            6'b110001: return ~y;
            6'b001111: return -x;
            6'b110011: return -y;
            6'b011111: return x + 16'd1;
            6'b110111: return y + 16'd1;
            6'b001110: return x - 16'd1;
            6'b110010: return y - 16'd1;
            6'b000010: return x + y;
            6'b010011: return x - y;
            6'b000111: return y - x;
            6'b000000: return x & y;
            6'b010101: return x | y;
            default:   return 16'hxxxx;
        endcase
    endfunction

    function automatic logic model_jump(input logic [2:0] j, input logic [15:0] r);
        int sv;
        sv = int'($signed(r));
        return (j[2] && sv < 0) || (j[1] && sv == 0) || (j[0] && sv > 0);
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic model_reset();
        m_a = '0; m_d = '0; m_pc = '0; m_halted = 1'b0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0; instr_valid = 1'b0; mem_ready = 1'b0;
        @(negedge clk);
        chk("rst_mem_req", 32'(mem_req), 0);
        chk("rst_writeM", 32'(writeM), 0);
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        @(negedge clk);
        chk("rst_fetch_req", 32'(fetch_req), 1);
        chk("rst_pc", 32'(pc), 0);
        chk("rst_A", 32'(addressM), 0);
        chk("rst_D", 32'(alu_x), 0);
        chk("rst_ctrl", 32'({zx, nx, zy, ny, f, no}), 0);
`ifdef HACK_HALT_DETECT_EN
        chk("rst_halted", 32'(halted), 0);
`endif
    endtask

    // Feeds one instruction through fetch and execute, checking against the model.
    task automatic run_instr(input logic [15:0] ins, input int fdly, input int mwait, input logic [15:0] mval);
        int n;
        logic is_c, am, d1, d2, d3, needs, jmp;
        logic [15:0] y, res;
        logic [14:0] tgt;
        n = 0;
        while (fetch_req !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (fetch_req !== 1'b1) begin
            chk("fetch_timeout", 32'(fetch_req), 1);
            return;
        end
        chk("fetch_pc", 32'(pc), 32'(m_pc));
        chk("fetch_mem_req", 32'(mem_req), 0);
        for (int i = 0; i < fdly; i++) begin
            instr = 16'($urandom);
            instr_valid = 1'b0;
            mem_ready = 1'($urandom);
            @(negedge clk);
            chk("fetch_pc_stable", 32'(pc), 32'(m_pc));
        end
        instr = ins; instr_valid = 1'b1; inM = mval; mem_ready = 1'b0;
        @(negedge clk);
        instr_valid = 1'b0; instr = 16'($urandom);
        chk("exec_fetch_req", 32'(fetch_req), 0);

        is_c = ins[15]; am = ins[12];
        d1 = ins[5]; d2 = ins[4]; d3 = ins[3];
        needs = is_c && (am || d3);
        y = am ? mval : m_a;
        res = model_comp(ins[11:6], m_d, y);

        if (!is_c) begin
            chk("a_mem_req", 32'(mem_req), 0);
            mem_ready = 1'($urandom);
            @(negedge clk);
            mem_ready = 1'b0;
            m_a = ins;
            m_pc = m_pc + 15'd1;
        end else begin
            chk("c_alu_y", 32'(alu_y), 32'(y));
            if (needs) begin
                for (int i = 0; i <= mwait; i++) begin
                    chk("mem_req_held", 32'(mem_req), 1);
                    chk("writeM_held", 32'(writeM), 32'(d3));
                    chk("addressM_held", 32'(addressM), 32'(m_a[14:0]));
                    if (d3) chk("outM_held", 32'(outM), 32'(res));
                    chk("pc_wait", 32'(pc), 32'(m_pc));
                    mem_ready = (i == mwait);
                    @(negedge clk);
                end
                mem_ready = 1'b0;
            end else begin
                chk("nomem_mem_req", 32'(mem_req), 0);
                chk("nomem_writeM", 32'(writeM), 0);
                chk("alu_result", 32'(outM), 32'(res));
                mem_ready = 1'($urandom);
                @(negedge clk);
                mem_ready = 1'b0;
            end
            jmp = model_jump(ins[2:0], res);
            tgt = m_a[14:0];
            if (d1) m_a = res;
            if (d2) m_d = res;
`ifdef HACK_HALT_DETECT_EN
            if (jmp && tgt == m_pc) m_halted = 1'b1;
`endif
            m_pc = jmp ? tgt : m_pc + 15'd1;
        end
        chk("commit_pc", 32'(pc), 32'(m_pc));
        chk("commit_A", 32'(addressM), 32'(m_a[14:0]));
        chk("commit_D", 32'(alu_x), 32'(m_d));
        chk("commit_mem_req", 32'(mem_req), 0);
        chk("commit_fetch_req", 32'(fetch_req), 32'(!m_halted));
`ifdef HACK_HALT_DETECT_EN
        chk("commit_halted", 32'(halted), 32'(m_halted));
`endif
    endtask

    typedef struct {
        logic [15:0] ins;
        int          mwait;
        logic [15:0] mval;
        logic [15:0] ea;
        logic [15:0] ed;
        logic [14:0] epc;
    } vec_t;

    vec_t tbl [21];

    initial begin
        int wr0;
        logic [15:0] ins, r;
        logic [2:0] top;
        logic [5:0] comp;
        logic am;

        tbl[0]  = '{16'h0005, 0, 16'h0000, 16'd5,    16'd0,    15'd1};
        tbl[1]  = '{16'hEC10, 0, 16'h0000, 16'd5,    16'd5,    15'd2};
        tbl[2]  = '{16'h0009, 0, 16'h0000, 16'd9,    16'd5,    15'd3};
        tbl[3]  = '{16'hEC10, 0, 16'h0000, 16'd9,    16'd9,    15'd4};
        tbl[4]  = '{16'h0064, 0, 16'h0000, 16'd100,  16'd9,    15'd5};
        tbl[5]  = '{16'hE308, 3, 16'h0000, 16'd100,  16'd9,    15'd6};
        tbl[6]  = '{16'h0028, 0, 16'h0000, 16'd40,   16'd9,    15'd7};
        tbl[7]  = '{16'hEE90, 0, 16'h0000, 16'd40,   16'hFFFF, 15'd8};
        tbl[8]  = '{16'hE301, 0, 16'h0000, 16'd40,   16'hFFFF, 15'd9};
        tbl[9]  = '{16'h0003, 0, 16'h0000, 16'd3,    16'hFFFF, 15'd10};
        tbl[10] = '{16'hEC10, 0, 16'h0000, 16'd3,    16'd3,    15'd11};
        tbl[11] = '{16'h0028, 0, 16'h0000, 16'd40,   16'd3,    15'd12};
        tbl[12] = '{16'hE301, 0, 16'h0000, 16'd40,   16'd3,    15'd40};
        tbl[13] = '{16'hFC10, 2, 16'h1234, 16'd40,   16'h1234, 15'd41};
        tbl[14] = '{16'hEFF8, 1, 16'h0000, 16'd1,    16'd1,    15'd42};
        tbl[15] = '{16'h8C10, 0, 16'h0000, 16'd1,    16'd1,    15'd43};
        tbl[16] = '{16'h0032, 0, 16'h0000, 16'd50,   16'd1,    15'd44};
        tbl[17] = '{16'hEDE7, 0, 16'h0000, 16'd51,   16'd1,    15'd50};
        tbl[18] = '{16'h7FFF, 0, 16'h0000, 16'h7FFF, 16'd1,    15'd51};
        tbl[19] = '{16'hEA87, 0, 16'h0000, 16'h7FFF, 16'd1,    15'h7FFF};
        tbl[20] = '{16'h0001, 0, 16'h0000, 16'd1,    16'd1,    15'd0};

        do_reset();
        for (int i = 0; i < 21; i++) begin
            run_instr(tbl[i].ins, int'($urandom_range(0, 2)), tbl[i].mwait, tbl[i].mval);
            chk("tbl_A", 32'(addressM), 32'(tbl[i].ea[14:0]));
            chk("tbl_D", 32'(alu_x), 32'(tbl[i].ed));
            chk("tbl_pc", 32'(pc), 32'(tbl[i].epc));
        end

        // Reset asserted while a store waits on mem_ready.
        run_instr(16'h0009, 0, 0, 16'h0);
        run_instr(16'hEC10, 0, 0, 16'h0);
        run_instr(16'h0064, 0, 0, 16'h0);
        instr = 16'hE308; instr_valid = 1'b1;
        @(negedge clk);
        instr_valid = 1'b0;
        repeat (2) begin
            chk("rstmid_mem_req", 32'(mem_req), 1);
            chk("rstmid_writeM", 32'(writeM), 1);
            @(negedge clk);
        end
        wr0 = wr_cnt;
        rst_n = 1'b0;
        #1;
        chk("rstmid_writeM_drop", 32'(writeM), 0);
        chk("rstmid_mem_req_drop", 32'(mem_req), 0);
        mem_ready = 1'b1;
        @(negedge clk);
        mem_ready = 1'b0;
        rst_n = 1'b1;
        model_reset();
        @(negedge clk);
        chk("rstmid_no_write", 32'(wr_cnt), 32'(wr0));
        chk("rstmid_pc", 32'(pc), 0);
        chk("rstmid_fetch_req", 32'(fetch_req), 1);

        // Random programs against the instruction-level model.
        for (int i = 0; i < 300; i++) begin
            if ($urandom_range(0, 9) < 4) begin
                ins = {1'b0, 15'($urandom)};
            end else begin
                case ($urandom_range(0, 5))
                    0: top = 3'b100;
                    1: top = 3'b101;
                    2: top = 3'b110;
                    default: top = 3'b111;
                endcase
                comp = COMPS[$urandom_range(0, 17)];
                am = 1'($urandom);
                ins = {top, am, comp, 3'($urandom), 3'($urandom)};
                r = model_comp(comp, m_d, am ? inM : m_a);
                // Keep self-jumps out of the random stream; they are exercised separately.
                if (model_jump(ins[2:0], r) && m_a[14:0] == m_pc) ins[2:0] = 3'b000;
            end
            inM = 16'($urandom);
            run_instr(ins, int'($urandom_range(0, 2)), int'($urandom_range(0, 3)), inM);
        end

`ifdef HACK_HALT_DETECT_EN
        do_reset();
        run_instr(16'h0007, 0, 0, 16'h0);
        run_instr(16'hEA87, 0, 0, 16'h0);
        run_instr(16'h0008, 0, 0, 16'h0);
        run_instr(16'hEA87, 0, 0, 16'h0);
        repeat (4) begin
            instr_valid = 1'b1;
            @(negedge clk);
            chk("halt_halted", 32'(halted), 1);
            chk("halt_fetch_req", 32'(fetch_req), 0);
            chk("halt_mem_req", 32'(mem_req), 0);
            chk("halt_pc", 32'(pc), 8);
        end
        instr_valid = 1'b0;
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
